// File: rtl/conv_pe_pkg.sv
// Shared definitions for the convolution PE array: controller states, default
// sizing constants and the per-lane requantise/saturate arithmetic.
package conv_pe_pkg;

    localparam int DEF_NUM_PE = 256;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 27;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    // Round-half-up arithmetic right shift, optional ReLU, then clamp to a
    // signed data_w range. Evaluated at 64 bits so no accumulator width overflows.
    function automatic logic signed [63:0] requant_sat(
        input logic signed [63:0] acc,
        input logic        [4:0]  shift,
        input logic               relu,
        input int                 data_w
    );
        logic signed [63:0] bias;
        logic signed [63:0] r;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        bias  = (shift != 5'd0) ? (64'sd1 <<< (shift - 5'd1)) : 64'sd0;
        r     = (acc + bias) >>> shift;
        if (relu && (r < 64'sd0)) begin
            r = 64'sd0;
        end
        max_v = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (data_w - 1));
        if (r > max_v) begin
            r = max_v;
        end else if (r < min_v) begin
            r = min_v;
        end
        return r;
    endfunction

endpackage

// File: rtl/conv_pe_lane.sv
// One MAC lane: signed multiply-accumulate of ifm*weight, with the output
// pixel requantised combinationally from the held accumulator.
module conv_pe_lane
    import conv_pe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     acc_en,
    input  logic        [4:0]        shift,
    input  logic                     relu,
    input  logic signed [DATA_W-1:0] ifm,
    input  logic signed [DATA_W-1:0] weight,
    output logic        [DATA_W-1:0] ofm
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    acc_d;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [63:0]         acc_ext;

    assign prod     = ifm * weight;
    assign prod_ext = {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign acc_ext  = {{(64 - ACC_W){acc_q[ACC_W-1]}}, acc_q};

    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (acc_en) begin
            acc_d = acc_q + prod_ext;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // The accumulator is frozen while the result is presented, so this stays stable.
    assign ofm = DATA_W'(requant_sat(acc_ext, shift, relu, DATA_W));

endmodule

// File: rtl/conv_pe_array_ctrl.sv
// Job controller for a NUM_PE-lane convolution MAC array: latches the job
// configuration, sequences kpix*nch operand beats and hands off the result.
module conv_pe_array_ctrl
    import conv_pe_pkg::*;
#(
    parameter int NUM_PE = DEF_NUM_PE,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic [3:0]                 cfg_kpix,
    input  logic [7:0]                 cfg_nch,
    input  logic [4:0]                 cfg_shift,
    input  logic                       cfg_relu,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_PE*DATA_W-1:0]   ifm,
    input  logic [DATA_W-1:0]          weight,
    output logic [NUM_PE*DATA_W-1:0]   ofm,
    output logic                       ofm_valid,
    input  logic                       ofm_ready,
    output logic                       busy,
    output logic                       done
);

    state_t      state_q, state_d;
    logic [3:0]  pix_q, pix_d;
    logic [7:0]  ch_q, ch_d;
    logic [3:0]  kpix_q, kpix_d;
    logic [7:0]  nch_q, nch_d;
    logic [4:0]  shift_q, shift_d;
    logic        relu_q, relu_d;
    logic        clear;
    logic        beat;
    logic        last_beat;
    logic        done_d;

    assign last_beat = (pix_q == kpix_q - 4'd1) && (ch_q == nch_q - 8'd1);

    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        ch_d    = ch_q;
        kpix_d  = kpix_q;
        nch_d   = nch_q;
        shift_d = shift_q;
        relu_d  = relu_q;
        clear   = 1'b0;
        beat    = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    kpix_d  = (cfg_kpix == 4'd0) ? 4'd1 : cfg_kpix;
                    nch_d   = (cfg_nch == 8'd0) ? 8'd1 : cfg_nch;
                    shift_d = cfg_shift;
                    relu_d  = cfg_relu;
                    clear   = 1'b1;
                    pix_d   = 4'd0;
                    ch_d    = 8'd0;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (in_valid) begin
                    beat = 1'b1;
                    if (last_beat) begin
                        pix_d   = 4'd0;
                        ch_d    = 8'd0;
                        state_d = ST_OUT;
                    end else if (pix_q == kpix_q - 4'd1) begin
                        pix_d = 4'd0;
                        ch_d  = ch_q + 8'd1;
                    end else begin
                        pix_d = pix_q + 4'd1;
                    end
                end
            end
            ST_OUT: begin
                if (ofm_ready) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort wins over everything, including a start in the same cycle.
        if (abort) begin
            state_d = ST_IDLE;
            pix_d   = 4'd0;
            ch_d    = 8'd0;
            kpix_d  = kpix_q;
            nch_d   = nch_q;
            shift_d = shift_q;
            relu_d  = relu_q;
            clear   = 1'b0;
            beat    = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            pix_q   <= 4'd0;
            ch_q    <= 8'd0;
            kpix_q  <= 4'd0;
            nch_q   <= 8'd0;
            shift_q <= 5'd0;
            relu_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            ch_q    <= ch_d;
            kpix_q  <= kpix_d;
            nch_q   <= nch_d;
            shift_q <= shift_d;
            relu_q  <= relu_d;
        end
    end

    assign in_ready  = (state_q == ST_ACCUM);
    assign ofm_valid = (state_q == ST_OUT);
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_d;

    for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_lane
        logic [DATA_W-1:0] lane_ofm;

        conv_pe_lane #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .clear   (clear),
            .acc_en  (beat),
            .shift   (shift_q),
            .relu    (relu_q),
            .ifm     (ifm[gi*DATA_W +: DATA_W]),
            .weight  (weight),
            .ofm     (lane_ofm)
        );

        // Outside the result phase the bus reads as zero.
        assign ofm[gi*DATA_W +: DATA_W] = ofm_valid ? lane_ofm : '0;
    end

endmodule

// File: tb/tb_conv_pe_array_ctrl.sv
// Directed self-checking bench for conv_pe_array_ctrl with a 4-lane array.
module tb_conv_pe_array_ctrl;

    localparam int NUM_PE = 4;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 27;
    localparam int VW     = NUM_PE * DATA_W;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic          abort;
    logic [3:0]    cfg_kpix;
    logic [7:0]    cfg_nch;
    logic [4:0]    cfg_shift;
    logic          cfg_relu;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] ifm;
    logic [7:0]    weight;
    logic [VW-1:0] ofm;
    logic          ofm_valid;
    logic          ofm_ready;
    logic          busy;
    logic          done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    conv_pe_array_ctrl #(
        .NUM_PE (NUM_PE),
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .abort     (abort),
        .cfg_kpix  (cfg_kpix),
        .cfg_nch   (cfg_nch),
        .cfg_shift (cfg_shift),
        .cfg_relu  (cfg_relu),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ifm       (ifm),
        .weight    (weight),
        .ofm       (ofm),
        .ofm_valid (ofm_valid),
        .ofm_ready (ofm_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [VW-1:0] rep(input logic [7:0] b);
        logic [VW-1:0] r;
        for (int i = 0; i < NUM_PE; i++) r[i*8 +: 8] = b;
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ifm_all(input logic [7:0] v);
        ifm = rep(v);
    endtask

    // Start a job, then scramble the cfg inputs so a non-latching design misbehaves.
    task automatic start_job(input logic [3:0] k, input logic [7:0] n,
                             input logic [4:0] s, input logic r);
        cfg_kpix  = k;
        cfg_nch   = n;
        cfg_shift = s;
        cfg_relu  = r;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        cfg_kpix  = 4'd1;
        cfg_nch   = 8'd1;
        cfg_shift = 5'd31;
        cfg_relu  = ~r;
    endtask

    task automatic feed(input int n, input int max_gap);
        int g;
        for (int i = 0; i < n; i++) begin
            g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            in_valid = 1'b0;
            repeat (g) tick();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic accept_result;
        ofm_ready = 1'b1;
        tick();
        ofm_ready = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else pass_cnt++;
        total_cnt++;
        if (ofm_valid !== 1'b0) $display("FAIL reset_ofm_valid: got %b want 0", ofm_valid); else pass_cnt++;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
        total_cnt++;
        if (ofm !== '0) $display("FAIL reset_ofm: got %h want 0", ofm); else pass_cnt++;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL post_reset_idle: busy got %b want 0", busy); else pass_cnt++;
        $display("reset: done");
    endtask

    task automatic test_basic;
        set_ifm_all(8'd2);
        weight = 8'd3;
        start_job(4'd9, 8'd1, 5'd0, 1'b0);
        total_cnt++;
        if (busy !== 1'b1 || in_ready !== 1'b1)
            $display("FAIL basic_accum: busy=%b in_ready=%b want 1/1", busy, in_ready);
        else pass_cnt++;
        feed(8, 0);
        total_cnt++;
        if (ofm_valid !== 1'b0) $display("FAIL basic_early_valid: got %b want 0", ofm_valid); else pass_cnt++;
        feed(1, 0);
        total_cnt++;
        if (ofm_valid !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL basic_valid: ofm_valid=%b in_ready=%b want 1/0", ofm_valid, in_ready);
        else pass_cnt++;
        total_cnt++;
        if (ofm !== rep(8'h36)) $display("FAIL basic_ofm: got %h want %h", ofm, rep(8'h36)); else pass_cnt++;
        ofm_ready = 1'b1;
        #1;
        total_cnt++;
        if (done !== 1'b1) $display("FAIL basic_done: got %b want 1", done); else pass_cnt++;
        tick();
        ofm_ready = 1'b0;
        total_cnt++;
        if (ofm_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0)
            $display("FAIL basic_after: ofm_valid=%b done=%b busy=%b want 0/0/0", ofm_valid, done, busy);
        else pass_cnt++;
        $display("basic: ofm=%h", rep(8'h36));
    endtask

    task automatic test_saturate;
        logic [7:0] wt  [3] = '{8'h7F, 8'h80, 8'h80};
        logic       rl  [3] = '{1'b0, 1'b0, 1'b1};
        logic [7:0] exp [3] = '{8'h7F, 8'h80, 8'h00};
        for (int t = 0; t < 3; t++) begin
            set_ifm_all(8'h7F);
            weight = wt[t];
            start_job(4'd9, 8'd3, 5'd4, rl[t]);
            feed(27, 0);
            total_cnt++;
            if (ofm_valid !== 1'b1 || ofm !== rep(exp[t]))
                $display("FAIL saturate_%0d: valid=%b ofm=%h want 1/%h", t, ofm_valid, ofm, rep(exp[t]));
            else pass_cnt++;
            accept_result();
            $display("saturate %0d: weight=%h relu=%b expect %h", t, wt[t], rl[t], exp[t]);
        end
    endtask

    task automatic test_round;
        logic [7:0] iv  [2] = '{8'h05, 8'hFB};
        logic [7:0] exp [2] = '{8'h03, 8'hFE};
        for (int t = 0; t < 2; t++) begin
            set_ifm_all(iv[t]);
            weight = 8'd1;
            start_job(4'd1, 8'd1, 5'd1, 1'b0);
            feed(1, 0);
            total_cnt++;
            if (ofm_valid !== 1'b1 || ofm !== rep(exp[t]))
                $display("FAIL round_%0d: valid=%b ofm=%h want 1/%h", t, ofm_valid, ofm, rep(exp[t]));
            else pass_cnt++;
            accept_result();
            $display("round %0d: ifm=%h expect %h", t, iv[t], exp[t]);
        end
    endtask

    // Distinct per-lane pixels; kpix=0 must behave as 1.
    task automatic test_lanes;
        ifm    = {8'hFE, 8'h02, 8'hFF, 8'h01};
        weight = 8'd3;
        start_job(4'd0, 8'd2, 5'd0, 1'b0);
        feed(1, 0);
        total_cnt++;
        if (ofm_valid !== 1'b0) $display("FAIL lanes_early: got %b want 0", ofm_valid); else pass_cnt++;
        feed(1, 0);
        total_cnt++;
        if (ofm_valid !== 1'b1 || ofm !== 32'hF40CFA06)
            $display("FAIL lanes_ofm: valid=%b ofm=%h want 1/f40cfa06", ofm_valid, ofm);
        else pass_cnt++;
        accept_result();
        $display("lanes: expect f40cfa06");
    endtask

    task automatic test_gaps;
        logic [VW-1:0] held;
        logic          stable;
        int            done_seen;
        set_ifm_all(8'd2);
        weight = 8'd3;
        start_job(4'd9, 8'd1, 5'd0, 1'b0);
        feed(9, 3);
        total_cnt++;
        if (ofm_valid !== 1'b1 || ofm !== rep(8'h36))
            $display("FAIL gaps_ofm: valid=%b ofm=%h want 1/%h", ofm_valid, ofm, rep(8'h36));
        else pass_cnt++;
        held      = ofm;
        stable    = 1'b1;
        done_seen = 0;
        ofm_ready = 1'b0;
        start     = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (done === 1'b1) done_seen++;
            tick();
            if (ofm !== held || ofm_valid !== 1'b1) stable = 1'b0;
        end
        total_cnt++;
        if (stable !== 1'b1) $display("FAIL gaps_stable: got %b want 1", stable); else pass_cnt++;
        ofm_ready = 1'b1;
        #1;
        if (done === 1'b1) done_seen++;
        tick();
        ofm_ready = 1'b0;
        if (done === 1'b1) done_seen++;
        total_cnt++;
        if (done_seen != 1) $display("FAIL gaps_done_count: got %0d want 1", done_seen); else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL gaps_start_ignored: busy got %b want 0", busy); else pass_cnt++;
        start = 1'b0;
        $display("gaps: ofm held %h", held);
    endtask

    task automatic test_back_to_back;
        set_ifm_all(8'd7);
        weight = 8'd2;
        start_job(4'd1, 8'd1, 5'd0, 1'b0);
        feed(1, 0);
        total_cnt++;
        if (ofm !== rep(8'h0E)) $display("FAIL b2b_first: got %h want %h", ofm, rep(8'h0E)); else pass_cnt++;
        accept_result();
        set_ifm_all(8'hFD);
        weight = 8'd5;
        start_job(4'd1, 8'd1, 5'd0, 1'b0);
        feed(1, 0);
        total_cnt++;
        if (ofm_valid !== 1'b1 || ofm !== rep(8'hF1))
            $display("FAIL b2b_second: valid=%b ofm=%h want 1/%h", ofm_valid, ofm, rep(8'hF1));
        else pass_cnt++;
        accept_result();
        $display("back_to_back: expect 0e then f1");
    endtask

    task automatic test_abort;
        set_ifm_all(8'd1);
        weight = 8'd1;
        start_job(4'd9, 8'd1, 5'd0, 1'b0);
        feed(4, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total_cnt++;
        if (busy !== 1'b0 || ofm_valid !== 1'b0 || done !== 1'b0)
            $display("FAIL abort_accum: busy=%b valid=%b done=%b want 0/0/0", busy, ofm_valid, done);
        else pass_cnt++;
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL abort_beats_start: busy got %b want 0", busy); else pass_cnt++;
        start_job(4'd9, 8'd1, 5'd0, 1'b0);
        feed(9, 0);
        total_cnt++;
        if (ofm_valid !== 1'b1 || ofm !== rep(8'h09))
            $display("FAIL abort_next_job: valid=%b ofm=%h want 1/%h", ofm_valid, ofm, rep(8'h09));
        else pass_cnt++;
        accept_result();
        start_job(4'd1, 8'd1, 5'd0, 1'b0);
        feed(1, 0);
        ofm_ready = 1'b1;
        abort     = 1'b1;
        #1;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL abort_out_done: got %b want 0", done); else pass_cnt++;
        tick();
        ofm_ready = 1'b0;
        abort     = 1'b0;
        total_cnt++;
        if (ofm_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL abort_out_idle: valid=%b busy=%b want 0/0", ofm_valid, busy);
        else pass_cnt++;
        $display("abort: next job expect 09");
    endtask

    task automatic test_reset_out;
        set_ifm_all(8'd2);
        weight = 8'd3;
        start_job(4'd9, 8'd1, 5'd0, 1'b0);
        feed(9, 0);
        #2;
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if (ofm_valid !== 1'b0 || busy !== 1'b0 || ofm !== '0)
            $display("FAIL reset_out_async: valid=%b busy=%b ofm=%h want 0/0/0", ofm_valid, busy, ofm);
        else pass_cnt++;
        tick();
        reset_n = 1'b1;
        tick();
        start_job(4'd9, 8'd1, 5'd0, 1'b0);
        feed(9, 0);
        total_cnt++;
        if (ofm_valid !== 1'b1 || ofm !== rep(8'h36))
            $display("FAIL reset_out_rerun: valid=%b ofm=%h want 1/%h", ofm_valid, ofm, rep(8'h36));
        else pass_cnt++;
        accept_result();
        $display("reset_out: rerun expect 36");
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        cfg_kpix  = 4'd0;
        cfg_nch   = 8'd0;
        cfg_shift = 5'd0;
        cfg_relu  = 1'b0;
        in_valid  = 1'b0;
        ifm       = '0;
        weight    = 8'd0;
        ofm_ready = 1'b0;
        test_reset();
        test_basic();
        test_saturate();
        test_round();
        test_lanes();
        test_gaps();
        test_back_to_back();
        test_abort();
        test_reset_out();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
